// File: rtl/axi3_line_refill_pkg.sv
// Shared types for the AXI3 read-refill path: address/data aliases, AXI3 read
// channel structs, burst/size encodings and the refill FSM state.
package axi3_line_refill_pkg;

    typedef logic [31:0] phys_t;
    typedef logic [31:0] uint32_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } refill_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    // Master-driven AR fields plus the R-channel ready.
    typedef struct packed {
        logic       arvalid;
        phys_t      araddr;
        logic [3:0] arlen;
        logic [2:0] arsize;
        logic [1:0] arburst;
        logic [1:0] arlock;
        logic [3:0] arcache;
        logic [2:0] arprot;
        logic       rready;
    } axi3_rd_req_t;

    // Slave-driven AR ready plus the R-channel payload.
    typedef struct packed {
        logic       arready;
        logic       rvalid;
        uint32_t    rdata;
        logic [1:0] rresp;
        logic       rlast;
    } axi3_rd_resp_t;

endpackage

// File: rtl/axi3_line_refill.sv
// Turns one cache-line refill (or uncached load) into a single AXI3 read burst,
// streaming each beat out for early restart and assembling the full line.
module axi3_line_refill
    import axi3_line_refill_pkg::*;
#(
    parameter int          LINE_WORDS = 8,
    parameter int          BUS_WIDTH  = 4,
    parameter int unsigned ARID       = 0,
    parameter bit          WRAP_MODE  = 1'b1,
    localparam int         IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  phys_t                      req_addr,
    input  logic                       req_uncached,
    output logic                       word_valid,
    output logic [IDX_W-1:0]           word_idx,
    output uint32_t                    word_data,
    output logic                       line_valid,
    output logic [LINE_WORDS*32-1:0]   line_data,
    output logic                       line_err,
    output logic [BUS_WIDTH-1:0]       arid,
    output axi3_rd_req_t               axi_req,
    input  axi3_rd_resp_t              axi_resp,
    input  logic [BUS_WIDTH-1:0]       rid
);

    refill_state_t                    state_q, state_d;
    phys_t                            araddr_q;
    logic [3:0]                       arlen_q;
    logic [2:0]                       arsize_q;
    logic [1:0]                       arburst_q;
    logic [IDX_W-1:0]                 idx_q;
    logic                             err_q;
    logic [LINE_WORDS-1:0][31:0]      line_q;

    logic                             accept;
    logic                             beat;
    phys_t                            line_base;
    phys_t                            word_addr;
    logic                             rid_unused;

    // Only one transaction is ever in flight, so the returned ID carries no information.
    assign rid_unused = ^{rid, axi_resp.rresp[0]};

    assign accept    = (state_q == IDLE) && req_valid;
    assign beat      = (state_q == DATA) && axi_resp.rvalid;
    assign line_base = req_addr & ~phys_t'(LINE_WORDS * 4 - 1);
    assign word_addr = {req_addr[31:2], 2'b00};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = ADDR;
            ADDR:    if (axi_resp.arready) state_d = DATA;
            DATA:    if (axi_resp.rvalid && axi_resp.rlast) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // AR fields are latched at accept and held, so they cannot move while arvalid is up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
        end else if (accept) begin
            arsize_q <= AXI_SIZE_4B;
            err_q    <= 1'b0;
            if (req_uncached) begin
                araddr_q  <= word_addr;
                arlen_q   <= 4'd0;
                arburst_q <= AXI_BURST_INCR;
                idx_q     <= req_addr[2 +: IDX_W];
            end else if (WRAP_MODE) begin
                araddr_q  <= word_addr;
                arlen_q   <= 4'(LINE_WORDS - 1);
                arburst_q <= AXI_BURST_WRAP;
                idx_q     <= req_addr[2 +: IDX_W];
            end else begin
                araddr_q  <= line_base;
                arlen_q   <= 4'(LINE_WORDS - 1);
                arburst_q <= AXI_BURST_INCR;
                idx_q     <= '0;
            end
        end else if (beat) begin
            err_q <= err_q | axi_resp.rresp[1];
            // LINE_WORDS is a power of two, so the natural overflow is the wrap.
            idx_q <= idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else if (beat) begin
            line_q[idx_q] <= axi_resp.rdata;
        end
    end

    always_comb begin
        axi_req         = '0;
        axi_req.arvalid = (state_q == ADDR);
        axi_req.araddr  = araddr_q;
        axi_req.arlen   = arlen_q;
        axi_req.arsize  = arsize_q;
        axi_req.arburst = arburst_q;
        axi_req.rready  = (state_q == DATA);
    end

    assign arid       = BUS_WIDTH'(ARID);
    assign req_ready  = (state_q == IDLE);
    assign word_valid = beat;
    assign word_idx   = idx_q;
    assign word_data  = axi_resp.rdata;
    assign line_valid = (state_q == DONE);
    assign line_err   = (state_q == DONE) && err_q;
    assign line_data  = line_q;

endmodule

// File: tb/tb_axi3_line_refill.sv
// Bench for axi3_line_refill: a WRAP and an INCR instance share one slave model;
// a vector table drives transactions and a beat scoreboard checks early restart.
module tb_axi3_line_refill;
    import axi3_line_refill_pkg::*;

    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          req_valid, req_uncached;
    phys_t         req_addr;
    axi3_rd_resp_t axi_resp;
    logic [3:0]    rid;

    logic              w_req_ready, w_word_valid, w_line_valid, w_line_err;
    logic [2:0]        w_word_idx;
    uint32_t           w_word_data;
    logic [LW*32-1:0]  w_line_data;
    logic [3:0]        w_arid;
    axi3_rd_req_t      w_axi;

    logic              i_req_ready, i_word_valid, i_line_valid, i_line_err;
    logic [2:0]        i_word_idx;
    uint32_t           i_word_data;
    logic [LW*32-1:0]  i_line_data;
    logic [3:0]        i_arid;
    axi3_rd_req_t      i_axi;

    axi3_line_refill #(.LINE_WORDS(LW), .BUS_WIDTH(4), .ARID(5), .WRAP_MODE(1'b1)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(w_req_ready),
        .req_addr(req_addr), .req_uncached(req_uncached), .word_valid(w_word_valid),
        .word_idx(w_word_idx), .word_data(w_word_data), .line_valid(w_line_valid),
        .line_data(w_line_data), .line_err(w_line_err), .arid(w_arid),
        .axi_req(w_axi), .axi_resp(axi_resp), .rid(rid));

    axi3_line_refill #(.LINE_WORDS(LW), .BUS_WIDTH(4), .ARID(0), .WRAP_MODE(1'b0)) dut_incr (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(i_req_ready),
        .req_addr(req_addr), .req_uncached(req_uncached), .word_valid(i_word_valid),
        .word_idx(i_word_idx), .word_data(i_word_data), .line_valid(i_line_valid),
        .line_data(i_line_data), .line_err(i_line_err), .arid(i_arid),
        .axi_req(i_axi), .axi_resp(axi_resp), .rid(rid));

    typedef struct {
        phys_t      addr;
        logic       unc;
        int         ar_dly;
        logic [7:0] gaps;      // bit k: one idle cycle before beat k
        int         err_beat;
        phys_t      w_araddr;
        phys_t      i_araddr;
        logic [3:0] arlen;
        logic [1:0] w_burst;
        logic [1:0] i_burst;
        int         w_start;
        int         i_start;
        logic       err;
    } vec_t;

    typedef struct {
        int      idx;
        uint32_t data;
    } beat_t;

    vec_t    vecs[5];
    beat_t   qw[$], qi[$];
    uint32_t mw[LW], mi[LW];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pack_line(input int sel);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < LW; k++) r[32*k +: 32] = (sel == 0) ? mw[k] : mi[k];
        return r;
    endfunction

    // Scoreboard: every accepted beat must match the oldest expected beat.
    beat_t b;
    always @(negedge clk) if (rst_n) begin
        if (w_word_valid) begin
            if (qw.size() == 0) chk("w_unexpected_beat", 1, 0);
            else begin
                b = qw.pop_front();
                chk("w_word_idx", w_word_idx, b.idx);
                chk("w_word_data", w_word_data, b.data);
            end
        end
        if (i_word_valid) begin
            if (qi.size() == 0) chk("i_unexpected_beat", 1, 0);
            else begin
                b = qi.pop_front();
                chk("i_word_idx", i_word_idx, b.idx);
                chk("i_word_data", i_word_data, b.data);
            end
        end
    end

    task automatic chk_reset_state();
        chk("rst_req_ready", {w_req_ready, i_req_ready}, 2'b11);
        chk("rst_arvalid", {w_axi.arvalid, i_axi.arvalid}, 2'b00);
        chk("rst_rready", {w_axi.rready, i_axi.rready}, 2'b00);
        chk("rst_word_valid", {w_word_valid, i_word_valid}, 2'b00);
        chk("rst_line_valid", {w_line_valid, i_line_valid}, 2'b00);
        chk("rst_line_err", {w_line_err, i_line_err}, 2'b00);
        chk("rst_ar_fields", {w_axi.araddr, w_axi.arlen, w_axi.arsize, w_axi.arburst}, '0);
        chk("rst_w_line_data", w_line_data, '0);
        chk("rst_i_line_data", i_line_data, '0);
    endtask

    task automatic run_txn(input vec_t v, input int t, input int abort_at);
        int nb, ngaps, start_cyc, wi, ii;
        uint32_t d;
        nb = v.unc ? 1 : LW;
        ngaps = 0;
        for (int k = 0; k < nb; k++) if (v.gaps[k]) ngaps++;

        chk("idle_req_ready", {w_req_ready, i_req_ready}, 2'b11);
        req_valid = 1'b1; req_addr = v.addr; req_uncached = v.unc;
        @(posedge clk); #1;
        start_cyc = cyc;
        // Requests and address changes while busy must have no effect.
        req_addr = ~v.addr; req_uncached = ~v.unc;

        for (int s = 0; s <= v.ar_dly; s++) begin
            axi_resp.arready = (s == v.ar_dly);
            axi_resp.rvalid  = (s < v.ar_dly);
            axi_resp.rlast   = 1'b1;
            axi_resp.rdata   = 32'hDEAD_0000 | s;
            chk("addr_arvalid", {w_axi.arvalid, i_axi.arvalid}, 2'b11);
            chk("addr_rready", {w_axi.rready, i_axi.rready}, 2'b00);
            chk("addr_req_ready", {w_req_ready, i_req_ready}, 2'b00);
            chk("w_araddr", w_axi.araddr, v.w_araddr);
            chk("i_araddr", i_axi.araddr, v.i_araddr);
            chk("arlen", {w_axi.arlen, i_axi.arlen}, {v.arlen, v.arlen});
            chk("arburst", {w_axi.arburst, i_axi.arburst}, {v.w_burst, v.i_burst});
            chk("arsize_lock_cache_prot", {w_axi.arsize, w_axi.arlock, w_axi.arcache, w_axi.arprot,
                i_axi.arsize, i_axi.arlock, i_axi.arcache, i_axi.arprot},
                {AXI_SIZE_4B, 9'd0, AXI_SIZE_4B, 9'd0});
            chk("arid", {w_arid, i_arid}, 8'h50);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        axi_resp.arready = 1'b0; axi_resp.rvalid = 1'b0; axi_resp.rlast = 1'b0;

        for (int k = 0; k < nb; k++) begin
            if (v.gaps[k]) begin
                axi_resp.rvalid = 1'b0;
                @(posedge clk); #1;
            end
            d = 32'hA000_0000 + (t << 8) + k;
            axi_resp.rvalid = 1'b1; axi_resp.rdata = d;
            axi_resp.rresp  = (k == v.err_beat) ? 2'b10 : 2'b00;
            axi_resp.rlast  = (k == nb - 1);
            chk("data_rready", {w_axi.rready, i_axi.rready}, 2'b11);
            if (k == abort_at) begin
                rst_n = 1'b0; #1;
                qw.delete(); qi.delete();
                for (int j = 0; j < LW; j++) begin mw[j] = '0; mi[j] = '0; end
                chk_reset_state();
                axi_resp = '0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(posedge clk); #1;
                chk_reset_state();
                return;
            end
            wi = (v.w_start + k) % LW;
            ii = (v.i_start + k) % LW;
            qw.push_back('{wi, d}); mw[wi] = d;
            qi.push_back('{ii, d}); mi[ii] = d;
            @(posedge clk); #1;
        end
        axi_resp.rvalid = 1'b0; axi_resp.rlast = 1'b0; axi_resp.rresp = 2'b00;

        chk("done_line_valid", {w_line_valid, i_line_valid}, 2'b11);
        chk("done_line_err", {w_line_err, i_line_err}, {v.err, v.err});
        chk("w_line_data", w_line_data, pack_line(0));
        chk("i_line_data", i_line_data, pack_line(1));
        chk("done_cycle", cyc - start_cyc + 1, 2 + v.ar_dly + nb + ngaps);
        chk("beats_outstanding", qw.size() + qi.size(), 0);
        @(posedge clk); #1;
        chk("post_line_valid", {w_line_valid, i_line_valid, w_line_err, i_line_err}, 4'b0000);
        chk("post_req_ready", {w_req_ready, i_req_ready}, 2'b11);
        chk("post_w_line_stable", w_line_data, pack_line(0));
    endtask

    initial begin
        vecs[0] = '{32'h1000_0014, 1'b0, 0, 8'h00, -1, 32'h1000_0014, 32'h1000_0000,
                    4'd7, AXI_BURST_WRAP, AXI_BURST_INCR, 5, 0, 1'b0};
        vecs[1] = '{32'h1FAF_0008, 1'b1, 0, 8'h00, -1, 32'h1FAF_0008, 32'h1FAF_0008,
                    4'd0, AXI_BURST_INCR, AXI_BURST_INCR, 2, 2, 1'b0};
        vecs[2] = '{32'h2000_003C, 1'b0, 4, 8'h2A, 3, 32'h2000_003C, 32'h2000_0020,
                    4'd7, AXI_BURST_WRAP, AXI_BURST_INCR, 7, 0, 1'b1};
        vecs[3] = '{32'h2000_0040, 1'b0, 1, 8'h81, -1, 32'h2000_0040, 32'h2000_0040,
                    4'd7, AXI_BURST_WRAP, AXI_BURST_INCR, 0, 0, 1'b0};
        vecs[4] = '{32'h3000_001E, 1'b1, 2, 8'h01, 0, 32'h3000_001C, 32'h3000_001C,
                    4'd0, AXI_BURST_INCR, AXI_BURST_INCR, 7, 7, 1'b1};
        for (int j = 0; j < LW; j++) begin mw[j] = '0; mi[j] = '0; end

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_uncached = 1'b0;
        axi_resp = '0; rid = 4'h3;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state();
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_txn(vecs[i], i, -1);

        // Reset lands during beat 4 of a WRAP refill; the next refill must be clean.
        run_txn(vecs[0], 8, 4);
        run_txn(vecs[3], 9, -1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi3_line_refill.md
# axi3_line_refill

Parametrised AXI3 read-burst engine that turns one cache-line refill or uncached-load request into a single AXI3 read transaction. It drives the `axi3_rd_if` master modport between the I$/D$ miss logic and the AXI3 crossbar. It generalises the fixed single-port read path:

- configurable line length and ARID;
- optional critical-word-first WRAP bursts;
- per-beat early-restart output;
- a sticky error flag.

## Interface
- `LINE_WORDS`, 8: 32-bit words per line; power of 2, 2..16 (arlen is 4 bits).
- `BUS_WIDTH`, 4: width of `arid`.
- `ARID`, 0: constant ID driven on `arid`.
- `WRAP_MODE`, 1: 1 = WRAP burst starting at the requested word; 0 = INCR burst from the line base.

Ports (`IDX_W` = $clog2(LINE_WORDS)):
- `clk` in 1: clock; single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: refill request.
- `req_ready` out 1: high only in IDLE.
- `req_addr` in 32 (`phys_t`): physical byte address.
- `req_uncached` in 1: single-beat read of `req_addr`.
- `word_valid` out 1: a beat is accepted this cycle.
- `word_idx` out `IDX_W`: word index of that beat within the line.
- `word_data` out 32: that beat's data (`rdata`).
- `line_valid` out 1: one-cycle done pulse.
- `line_data` out `LINE_WORDS*32`: assembled line; word i is at bits [32i+31:32i].
- `line_err` out 1: OR of `rresp[1]` over the finished transaction.
- `axi` `axi3_rd_if.master`: `arid`, `axi3_rd_req`, `axi3_rd_resp`, `rid`.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- **IDLE**: `req_ready=1`. On `req_valid`, latch the address, uncached flag and start index, clear the error accumulator, then go to ADDR.
- **ADDR**: `arvalid=1` with AR fields held constant; go to DATA on `arready`.
- **DATA**: `rready=1`. Each `rvalid` beat:
  - writes `rdata` into `line_data[idx]`;
  - pulses `word_valid` combinationally with `word_idx=idx` and `word_data=rdata`;
  - ORs `rresp[1]` into the error accumulator;
  - advances `idx` by 1 mod `LINE_WORDS`.
  On the beat with `rlast`, go to DONE.
- **DONE**: `line_valid=1` and `line_err` = accumulator for one cycle, then go to IDLE.
- AR fields:
  - `arsize=3'b010`, `arlock=0`, `arprot=0`, `arcache=0`, `arid=ARID`.
  - Cached, `WRAP_MODE=1`: `araddr={req_addr[31:2],2'b00}`, `arburst=2'b10`, `arlen=LINE_WORDS-1`, start idx = `req_addr[2+:IDX_W]`.
  - Cached, `WRAP_MODE=0`: `araddr` line-aligned, `arburst=2'b01`, `arlen=LINE_WORDS-1`, start idx = 0.
  - Uncached: `araddr` word-aligned, `arburst=2'b01`, `arlen=0`, start idx = `req_addr[2+:IDX_W]`.
- `rlast` is authoritative; the beat count is not checked. `rid` is ignored, since only one transaction is ever outstanding.
- Idx wrap-around: in WRAP mode, a start of 5 with `LINE_WORDS=8` gives the order 5,6,7,0,1,2,3,4.
- `line_data` words not written by the current transaction (uncached case) keep their old values. `line_data` is stable outside DATA.
- `req_valid` outside IDLE is ignored. It is not queued.

## Timing
- Reset values:
  - FSM = IDLE; `req_ready=1`.
  - `arvalid=0`, `rready=0`, `word_valid=0`, `line_valid=0`, `line_err=0`.
  - `line_data=0`; all AR fields 0.
- Request accepted at cycle 0. `arvalid` rises at cycle 1.
- With `arready` at cycle 1 and back-to-back beats from cycle 2, `rlast` arrives at cycle `1+LINE_WORDS`.
- `line_valid` is asserted at cycle `2+LINE_WORDS`. `req_ready` is back at cycle `3+LINE_WORDS`.
- `word_valid` has zero latency from `rvalid` in DATA.
- `arvalid` is never deasserted before `arready`. No AR field changes while `arvalid` is high.
- `rvalid` arriving in ADDR cannot be accepted: `rready=0` there.
- Reset mid-transaction: all outputs drop to reset values immediately (async). AXI protocol is only guaranteed across a system-wide reset.

## Structure
- Shared package additions:
  - `refill_state_t` enum (IDLE/ADDR/DATA/DONE);
  - burst encodings `AXI_BURST_INCR` / `AXI_BURST_WRAP`;
  - `AXI_SIZE_4B`.
- Reuses `phys_t`, `uint32_t` and the `axi3_rd_req_t` / `axi3_rd_resp_t` structs.
- Single module. A sub-module is not natural; the line buffer and index counter are inline registers.

## Test plan
- `LINE_WORDS=8`, `WRAP_MODE=1`, `req_addr=0x1000_0014`, zero-wait slave:
  - AR: `araddr=0x1000_0014`, `arlen=7`, `arburst=WRAP`;
  - `word_idx` sequence 5,6,7,0..4;
  - `line_valid` at cycle 10 with the words in the correct slots.
- `WRAP_MODE=0`, same address → `araddr=0x1000_0000`, `arburst=INCR`, `word_idx` sequence 0..7.
- Uncached read of `0x1FAF_0008`:
  - AR: `arlen=0`, single `word_valid` with `word_idx=2`;
  - other `line_data` words unchanged from the previous refill.
- `arready` delayed 4 cycles with `rvalid` gaps → AR fields stable throughout, `word_valid` only on handshake beats.
- `rresp=2'b10` on beat 3 → `line_err=1` with `line_valid`. The next clean refill gives `line_err=0`.
- Assert `rst_n` low during beat 4, then release → all outputs at reset values and `req_ready=1`. The next request completes normally.
